// File: rtl/zfsoc_debug_vji_master.sv
// Virtual-JTAG debug master: one command = UIR, CDR, SDR x DR_WIDTH, UDR [, RTI x RTI_TCKS] then a held response.
// Latency (3+DR_WIDTH[+RTI_TCKS])*2*TCK_DIV clk; rsp held until rsp_ready; RTI phase built only with ZFSOC_VJI_MASTER_RTI_EN.
module zfsoc_debug_vji_master #(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = 38,
  parameter int RTI_TCKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_uir,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  if (TCK_DIV < 1 || TCK_DIV > 255 || DR_WIDTH < 2 || RTI_TCKS < 1) begin : g_bad_param
    $error("zfsoc_debug_vji_master: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

  localparam int             BCW      = $clog2(DR_WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_WIDTH);
  localparam logic [7:0]     DIV_LAST = 8'(TCK_DIV - 1);

  state_t              state, period_next;
  logic [7:0]          div_cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [DR_WIDTH-1:0] shreg;
  logic                active, div_end, tck_rise, tck_fall;

`ifdef ZFSOC_VJI_MASTER_RTI_EN
  localparam int             RCW      = $clog2(RTI_TCKS + 1);
  localparam logic [RCW-1:0] RTI_LAST = RCW'(RTI_TCKS);
  logic [RCW-1:0] rti_cnt;
`else
  assign vji_rti = 1'b0;
`endif

  assign active   = (state != IDLE) && (state != RESP);
  assign div_end  = active && (div_cnt == DIV_LAST);
  assign tck_rise = div_end && !vji_tck;
  assign tck_fall = div_end && vji_tck;

  // State to enter when the current tck period ends (tck falling).
  always_comb begin
    period_next = state;
    case (state)
      UIR: period_next = CDR;
      CDR: period_next = SDR;
      SDR: if (bit_cnt == BIT_LAST) period_next = UDR;
`ifdef ZFSOC_VJI_MASTER_RTI_EN
      UDR: period_next = RTI;
      RTI: if (rti_cnt == RTI_LAST) period_next = RESP;
`else
      UDR: period_next = RESP;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_ir_in  <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_uir    <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef ZFSOC_VJI_MASTER_RTI_EN
      vji_rti    <= 1'b0;
      rti_cnt    <= '0;
`endif
    end else begin
      if (div_end) begin
        div_cnt <= '0;
        vji_tck <= ~vji_tck;
      end else if (active) begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (tck_rise) begin
        if (state == UIR) rsp_ir_out <= vji_ir_out;
        if (state == SDR) begin
          shreg   <= {vji_tdo, shreg[DR_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
`ifdef ZFSOC_VJI_MASTER_RTI_EN
        if (state == RTI) rti_cnt <= rti_cnt + 1'b1;
`endif
      end

      // tdi only moves on falling tck, so it is stable around every rising edge.
      if (tck_fall) begin
        state   <= period_next;
        vji_uir <= 1'b0;
        vji_cdr <= (period_next == CDR);
        vji_sdr <= (period_next == SDR);
        vji_udr <= (period_next == UDR);
`ifdef ZFSOC_VJI_MASTER_RTI_EN
        vji_rti <= (period_next == RTI);
`endif
        vji_tdi <= (period_next == SDR) ? shreg[0] : 1'b0;
        if (period_next == RESP) begin
          rsp_valid <= 1'b1;
          rsp_data  <= shreg;
        end
      end

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= UIR;
            cmd_ready <= 1'b0;
            vji_ir_in <= cmd_ir;
            shreg     <= cmd_data;
            vji_uir   <= 1'b1;
            vji_tck   <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
`ifdef ZFSOC_VJI_MASTER_RTI_EN
            rti_cnt   <= '0;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zfsoc_debug_vji_master.sv
// Directed bench for zfsoc_debug_vji_master (default build, RTI phase not compiled in).
module tb_zfsoc_debug_vji_master;

  localparam int DW = 38;

  int errors = 0;
  int checks = 0;

`define CHECK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, rsp_ready = 1'b0, tdo_tie = 1'b0;
  logic [1:0]    cmd_ir = 2'b00;
  logic [DW-1:0] cmd_data = '0;
  logic [1:0]    vji_ir_out = 2'b10;
  logic          cmd_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_ir_out, vji_ir_in;
  logic          vji_tck, vji_tdi, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti, vji_tdo;

  logic          d2_cmd_valid = 1'b0, d2_rsp_ready = 1'b0;
  logic          d2_cmd_ready, d2_rsp_valid;
  logic [DW-1:0] d2_rsp_data;
  logic [1:0]    d2_rsp_ir_out, d2_ir_in;
  logic          d2_tck, d2_tdi, d2_cdr, d2_sdr, d2_udr, d2_uir, d2_rti;

  assign vji_tdo = tdo_tie | vji_tdi;

  always #5 clk = ~clk;

  zfsoc_debug_vji_master #(.TCK_DIV(2), .DR_WIDTH(DW), .RTI_TCKS(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_uir(vji_uir), .vji_rti(vji_rti), .vji_ir_in(vji_ir_in),
    .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  zfsoc_debug_vji_master #(.TCK_DIV(1), .DR_WIDTH(DW), .RTI_TCKS(2)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_data(d2_rsp_data), .rsp_ir_out(d2_rsp_ir_out),
    .vji_tck(d2_tck), .vji_tdi(d2_tdi), .vji_cdr(d2_cdr), .vji_sdr(d2_sdr),
    .vji_udr(d2_udr), .vji_uir(d2_uir), .vji_rti(d2_rti), .vji_ir_in(d2_ir_in),
    .vji_tdo(d2_tdi), .vji_ir_out(vji_ir_out)
  );

  // Launch one command on dut and watch the slave side until rsp_valid.
  // lat counts clk edges from the accepting edge to the edge raising rsp_valid.
  task automatic run1(input logic [1:0] ir, input logic [DW-1:0] data,
                      output int lat, output logic [DW-1:0] tw, output int rises,
                      output int uir_cyc, output int ir_bad);
    logic prev_tck;
    int   n;
    tw = '0; rises = 0; uir_cyc = 0; ir_bad = 0; lat = 0; n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~data;
    prev_tck = 1'b0;
    while (!rsp_valid && lat < 2000) begin
      if (vji_uir) uir_cyc++;
      if (vji_ir_in !== ir) ir_bad++;
      if (vji_tck && !prev_tck && vji_sdr) begin rises++; tw = {vji_tdi, tw[DW-1:1]}; end
      prev_tck = vji_tck;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, rises, uir_cyc, ir_bad, bad, n, stuck;
    logic [DW-1:0] tw, held;
    logic prev;

    // Reset state
    @(negedge clk); @(negedge clk);
    `CHECK("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_ir_out, vji_ir_in, vji_tck, vji_tdi,
                             vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti}, '0)
    reset = 1'b0;
    `CHECK("cmd_ready_before_edge", cmd_ready, 1'b0)
    @(negedge clk);
    `CHECK("cmd_ready_after_edge", cmd_ready, 1'b1)

    // Loopback transaction
    tdo_tie = 1'b0;
    run1(2'b01, 38'h2_A5A5_A5A5, lat, tw, rises, uir_cyc, ir_bad);
    `CHECK("loop_latency", lat, (3 + DW) * 2 * 2)
    `CHECK("loop_rsp_data", rsp_data, 38'h2_A5A5_A5A5)
    `CHECK("loop_rsp_ir_out", rsp_ir_out, 2'b10)
    `CHECK("loop_ir_in_held", ir_bad, 0)
    `CHECK("loop_tdi_word", tw, 38'h2_A5A5_A5A5)
    `CHECK("loop_sdr_rises", rises, DW)
    `CHECK("loop_uir_cycles", uir_cyc, 4)
    `CHECK("loop_cmd_ready_busy", cmd_ready, 1'b0)
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    `CHECK("loop_rsp_done", {rsp_valid, cmd_ready}, 2'b01)

    // tdo tied high, zero data
    tdo_tie = 1'b1;
    run1(2'b11, '0, lat, tw, rises, uir_cyc, ir_bad);
    `CHECK("ones_rsp_data", rsp_data, {DW{1'b1}})
    `CHECK("ones_tdi_word", tw, {DW{1'b0}})
    `CHECK("ones_sdr_rises", rises, DW)
    `CHECK("ones_ir_in_held", ir_bad, 0)
    tdo_tie = 1'b0;

    // Response held off for 20 cycles; a command pulse meanwhile is ignored
    held = rsp_data; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin cmd_valid = 1'b1; cmd_data = 38'h0_1111_2222; end
      if (i == 11) cmd_valid = 1'b0;
      if (!rsp_valid || rsp_data !== held || cmd_ready) bad++;
      @(negedge clk);
    end
    `CHECK("hold_stable", bad, 0)
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    `CHECK("hold_release", {rsp_valid, cmd_ready}, 2'b01)
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (vji_uir || !cmd_ready || rsp_valid) bad++;
      @(negedge clk);
    end
    `CHECK("busy_cmd_ignored", bad, 0)

    // Reset during SDR bit 17
    cmd_ir = 2'b10; cmd_data = 38'h3_0F0F_F0F0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 18 && n < 1000) begin
      if (vji_tck && !prev && vji_sdr) rises++;
      prev = vji_tck;
      @(negedge clk);
      n++;
    end
    `CHECK("abort_reached_bit17", rises, 18)
    #2 reset = 1'b1;
    #1;
    `CHECK("abort_outputs_zero", {cmd_ready, rsp_valid, rsp_data, rsp_ir_out, vji_ir_in, vji_tck, vji_tdi,
                                  vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti}, '0)
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    `CHECK("abort_no_rsp", {rsp_valid, cmd_ready}, 2'b01)
    run1(2'b01, 38'h1_2345_6789, lat, tw, rises, uir_cyc, ir_bad);
    `CHECK("after_abort_data", rsp_data, 38'h1_2345_6789)
    `CHECK("after_abort_latency", lat, (3 + DW) * 2 * 2)
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // TCK_DIV = 1 instance
    n = 0;
    while (!d2_cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_ir = 2'b01; cmd_data = 38'h2_5A5A_3C3C; d2_cmd_valid = 1'b1;
    @(negedge clk);
    d2_cmd_valid = 1'b0; cmd_data = '0;
    lat = 0; stuck = 0; prev = 1'b0;
    while (!d2_rsp_valid && lat < 2000) begin
      if (lat > 0 && d2_tck === prev) stuck++;
      prev = d2_tck;
      @(negedge clk);
      lat++;
    end
    `CHECK("div1_latency", lat, (3 + DW) * 2)
    `CHECK("div1_tck_toggles", stuck, 0)
    `CHECK("div1_rsp_data", d2_rsp_data, 38'h2_5A5A_3C3C)
    `CHECK("div1_rsp_ir_out", d2_rsp_ir_out, 2'b10)
    d2_rsp_ready = 1'b1;
    @(negedge clk);
    d2_rsp_ready = 1'b0;
    `CHECK("div1_rsp_done", {d2_rsp_valid, d2_cmd_ready, d2_tck}, 3'b010)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
